relay_frame_ctrl: RTL

RELAY_FRAME_CTRL -- requirements
Module: relay_frame_ctrl

---
 rtl/relay_frame_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/relay_frame_ctrl.sv
// Frame capture controller: collects decoded bits into a right-aligned frame with idle timeout.
// Optional trailing parity bit check enabled by defining RELAY_FRAME_CTRL_PARITY_EN.
module relay_frame_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        mode_sel,
  input  logic [3:0]  frame_len,
  input  logic        frame_ack,
  input  logic [3:0]  dec_data,
  input  logic        dec_avail,
  output logic        dec_reset,
  output logic        dec_mode,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  output logic        timeout_err,
  output logic        parity_err,
  output logic        busy
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TO_VAL = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_DONE, S_ERROR} state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [3:0]    len_q, len_d;
  logic [15:0]   data_q, data_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [4:0]    len_eff;
  logic [IW-1:0] idle_inc;
  logic          bit_in;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  assign len_eff  = (len_q == 4'd0) ? 5'd16 : {1'b0, len_q};
  assign idle_inc = idle_q + IW'(1);
  assign bit_in   = |dec_data;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RECEIVE;
          mode_d  = mode_sel;
          len_d   = frame_len;
          data_d  = '0;
          cnt_d   = '0;
          idle_d  = '0;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
          par_d   = 1'b0;
          perr_d  = 1'b0;
`endif
        end
      end
      S_RECEIVE: begin
        // A bit arriving on the timeout cycle wins over the timeout.
        if (dec_avail) begin
          idle_d = '0;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
          if (cnt_q == len_eff) begin
            perr_d  = par_q ^ bit_in;
            state_d = S_DONE;
          end else begin
            data_d = {data_q[14:0], bit_in};
            cnt_d  = cnt_q + 5'd1;
            par_d  = par_q ^ bit_in;
          end
`else
          data_d = {data_q[14:0], bit_in};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == len_eff) state_d = S_DONE;
`endif
        end else begin
          idle_d = idle_inc;
          if (idle_inc == TO_VAL) state_d = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (frame_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
`ifdef RELAY_FRAME_CTRL_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dec_reset   = (state_q != S_RECEIVE);
  assign dec_mode    = mode_q;
  assign frame_data  = data_q;
  assign frame_valid = (state_q == S_DONE);
  assign timeout_err = (state_q == S_ERROR);
  assign busy        = (state_q != S_IDLE);
`ifdef RELAY_FRAME_CTRL_PARITY_EN
  assign parity_err  = perr_q & (state_q == S_DONE);
`else
  assign parity_err  = 1'b0;
`endif

endmodule
